// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl
// ------------
// Frame decoder sitting behind an SPI byte receiver. While slave select is low
// it arms the receiver byte by byte, collects a CMD/ADDR/DATA frame and then
// either writes one 8-bit config register (CMD 0xA5) or clears them all
// (CMD 0x3C). Malformed, timed-out or truncated frames are rejected with an
// error strobe and a held error code.
//
// Optional feature: define SPI_CMD_CHECKSUM_EN to extend the frame with a
// fourth CHK byte that must equal CMD^ADDR^DATA (error code 5 otherwise).
//
// Error codes: 1 bad opcode, 2 address out of range, 3 inter-byte timeout,
//              4 slave select released mid-frame, 5 checksum mismatch.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   ss_n       SPI slave select (asynchronous, active-low)
//   rx_data    received byte, valid while rx_finish is high
//   rx_finish  one-cycle pulse: byte complete
//   rx_start   one-cycle pulse arming the receiver for the next byte
//   cfg_o      flat register file, register n at [8n+7:8n]
//   wr_stb     one-cycle pulse on register write or clear
//   wr_addr    register index of the last commit (0 for clear)
//   busy       high while a frame is in progress
//   err_stb    one-cycle pulse on frame rejection
//   err_code   cause of the last rejection
module spi_cmd_ctrl #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int NUM_REGS    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ss_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_finish,
    output logic                  rx_start,
    output logic [8*NUM_REGS-1:0] cfg_o,
    output logic                  wr_stb,
    output logic [2:0]            wr_addr,
    output logic                  busy,
    output logic                  err_stb,
    output logic [2:0]            err_code
);

`ifdef SPI_CMD_CHECKSUM_EN
    localparam int FRAME_BYTES = 4;
    localparam logic [2:0] ERR_CHK = 3'd5;
`else
    localparam int FRAME_BYTES = 3;
`endif

    localparam logic [1:0]    LAST_IDX    = 2'(FRAME_BYTES - 1);
    localparam int            AW          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int            TW          = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]    NUM_REGS_B  = 8'(NUM_REGS);
    localparam logic [7:0]    CMD_WRITE   = 8'hA5;
    localparam logic [7:0]    CMD_CLEAR   = 8'h3C;
    localparam logic [2:0]    ERR_OPCODE  = 3'd1;
    localparam logic [2:0]    ERR_ADDR    = 3'd2;
    localparam logic [2:0]    ERR_TIMEOUT = 3'd3;
    localparam logic [2:0]    ERR_SS      = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_DECODE,
        S_COMMIT,
        S_ABORT
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    abort_code;
    logic          ss_meta, ss_sync, ss_prev;
    logic          ss_fall, ss_rise;
    logic [TW-1:0] timer_q;
    logic [1:0]    byte_cnt;
    logic [7:0]    cmd_q, addr_q, data_q;
`ifdef SPI_CMD_CHECKSUM_EN
    logic [7:0]    chk_q;
`endif
    logic [7:0]    regs_q [NUM_REGS];

    // Slave select crosses into clk through two flops; a third flop holds the
    // previous synchronized level so edges are seen only on clean data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_meta <= 1'b1;
            ss_sync <= 1'b1;
            ss_prev <= 1'b1;
        end else begin
            ss_meta <= ss_n;
            ss_sync <= ss_meta;
            ss_prev <= ss_sync;
        end
    end

    assign ss_fall = ss_prev & ~ss_sync;
    assign ss_rise = ~ss_prev & ss_sync;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic. A byte arriving together with a slave-select release
    // is taken first, so only a still-incomplete frame is aborted.
    always_comb begin
        state_d    = state_q;
        abort_code = 3'd0;
        case (state_q)
            S_IDLE: begin
                if (ss_fall) state_d = S_ARM;
            end
            S_ARM: begin
                if (ss_rise) begin
                    state_d    = S_ABORT;
                    abort_code = ERR_SS;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rx_finish) begin
                    if (byte_cnt == LAST_IDX) begin
                        state_d = S_DECODE;
                    end else if (ss_rise) begin
                        state_d    = S_ABORT;
                        abort_code = ERR_SS;
                    end else begin
                        state_d = S_ARM;
                    end
                end else if (ss_rise) begin
                    state_d    = S_ABORT;
                    abort_code = ERR_SS;
                end else if (timer_q == TMO_LAST) begin
                    state_d    = S_ABORT;
                    abort_code = ERR_TIMEOUT;
                end
            end
            S_DECODE: begin
`ifdef SPI_CMD_CHECKSUM_EN
                if (chk_q != (cmd_q ^ addr_q ^ data_q)) begin
                    state_d    = S_ABORT;
                    abort_code = ERR_CHK;
                end else
`endif
                if (cmd_q == CMD_WRITE) begin
                    if (addr_q >= NUM_REGS_B) begin
                        state_d    = S_ABORT;
                        abort_code = ERR_ADDR;
                    end else begin
                        state_d = S_COMMIT;
                    end
                end else if (cmd_q == CMD_CLEAR) begin
                    state_d = S_COMMIT;
                end else begin
                    state_d    = S_ABORT;
                    abort_code = ERR_OPCODE;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            S_ABORT:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Inter-byte timer: runs only while waiting for a byte and restarts on
    // every accepted byte and whenever the FSM leaves WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               timer_q <= '0;
        else if (state_q == S_WAIT && !rx_finish) timer_q <= timer_q + TW'(1);
        else                                      timer_q <= '0;
    end

    // Byte slots are filled in arrival order; the counter is reset whenever
    // the FSM is idle or aborting so every frame starts at the CMD slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= 2'd0;
            cmd_q    <= 8'h00;
            addr_q   <= 8'h00;
            data_q   <= 8'h00;
`ifdef SPI_CMD_CHECKSUM_EN
            chk_q    <= 8'h00;
`endif
        end else if (state_q == S_WAIT && rx_finish) begin
            case (byte_cnt)
                2'd0: cmd_q  <= rx_data;
                2'd1: addr_q <= rx_data;
                2'd2: data_q <= rx_data;
`ifdef SPI_CMD_CHECKSUM_EN
                2'd3: chk_q  <= rx_data;
`endif
                default: ;
            endcase
            byte_cnt <= byte_cnt + 2'd1;
        end else if (state_q == S_IDLE || state_q == S_ABORT) begin
            byte_cnt <= 2'd0;
        end
    end

    // Register file and last-commit index; only COMMIT changes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
            wr_addr <= 3'd0;
        end else if (state_q == S_COMMIT) begin
            if (cmd_q == CMD_CLEAR) begin
                for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
                wr_addr <= 3'd0;
            end else begin
                regs_q[addr_q[AW-1:0]] <= data_q;
                wr_addr                <= addr_q[2:0];
            end
        end
    end

    // Error code is latched on entry to ABORT so it is valid with err_stb.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 err_code <= 3'd0;
        else if (state_d == S_ABORT) err_code <= abort_code;
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg
        assign cfg_o[8*g +: 8] = regs_q[g];
    end

    assign rx_start = (state_q == S_ARM);
    assign wr_stb   = (state_q == S_COMMIT);
    assign err_stb  = (state_q == S_ABORT);
    assign busy     = (state_q != S_IDLE);

endmodule

// File: doc/spi_cmd_ctrl.md
SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 4096, max clk cycles allowed between consecutive bytes of one frame.
REQ-002 Parameter NUM_REGS, default 8, number of 8-bit config registers (power of 2, 2..8).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ss_n  input  1  SPI slave select, asynchronous to clk, active-low.
REQ-006 rx_data  input  8  byte from SPI byte receiver; valid only while rx_finish=1.
REQ-007 rx_finish  input  1  one-cycle pulse from receiver: byte complete.
REQ-008 rx_start  output  1  one-cycle pulse arming receiver for next byte.
REQ-009 cfg_o  output  8*NUM_REGS  flat config register file, reg n at bits [8n+7:8n].
REQ-010 wr_stb  output  1  one-cycle pulse when any register is written or cleared.
REQ-011 wr_addr  output  3  register index of last commit (0 for clear).
REQ-012 busy  output  1  high while a frame is in progress.
REQ-013 err_stb  output  1  one-cycle pulse on frame rejection.
REQ-014 err_code  output  3  cause of last rejection; held until next err_stb or reset.

Function
REQ-015 ss_n SHALL pass a 2-flop synchronizer; falling/rising edges detected on the synchronized signal.
REQ-016 Frame = CMD, ADDR, DATA bytes (plus CHK when CHECKSUM_EN); MSB-first content, byte order fixed.
REQ-017 States: IDLE, ARM, WAIT, DECODE, COMMIT, ABORT.
REQ-018 IDLE -> ARM on synchronized ss_n falling edge; ARM asserts rx_start for exactly one cycle, -> WAIT.
REQ-019 WAIT: on rx_finish capture rx_data into byte slot indexed by byte counter (0..2/3) in that same cycle; if more bytes needed -> ARM (rx_start the following cycle), else -> DECODE.
REQ-020 DECODE (1 cycle): CMD 0xA5 = write, CMD 0x3C = clear-all, else err_code=1; write with ADDR >= NUM_REGS: err_code=2; valid -> COMMIT, invalid -> ABORT.
REQ-021 COMMIT (1 cycle): write updates cfg_o[ADDR] to DATA, clear resets all registers to 0x00; wr_stb=1 same cycle, cfg_o visible next cycle; -> IDLE.
REQ-022 Latency last rx_finish -> wr_stb = 2 clk cycles.
REQ-023 Inter-byte timer counts cycles in WAIT, cleared on each rx_finish; reaching TIMEOUT_CYC -> ABORT, err_code=3.
REQ-024 Synchronized ss_n rising edge while busy and before DECODE -> ABORT, err_code=4; at/after DECODE frame completes normally.
REQ-025 ABORT (1 cycle): err_stb=1, no register change, byte counter and timer cleared; -> IDLE.
REQ-026 rx_finish outside WAIT SHALL be ignored; ss_n falling edge outside IDLE SHALL be ignored.
REQ-027 Simultaneous rx_finish and ss_n rising in WAIT: byte accepted first; abort applies only if frame still incomplete.
REQ-028 busy = state != IDLE.
REQ-029 Extra bytes after frame completion while ss_n still low are not armed; new frame requires fresh ss_n falling edge.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, cfg_o=0, counters/timer=0, synchronizer=1s, all strobes=0, err_code=0, wr_addr=0, busy=0.
REQ-031 Reset mid-frame SHALL discard partial frame without any commit.

Configuration
REQ-032 Macro SPI_CMD_CHECKSUM_EN defined: frame is 4 bytes; CHK must equal CMD^ADDR^DATA, mismatch in DECODE -> ABORT, err_code=5 (checked before opcode).
REQ-033 Macro undefined: frame is 3 bytes, no checksum logic, err_code 5 never produced.

Verification
REQ-034 ss_n fall, bytes A5,02,3C (+CHK 9B if enabled) -> rx_start 3(4) pulses, wr_stb 2 cycles after last byte, cfg_o[23:16]=0x3C, wr_addr=2.
REQ-035 Write regs 0..7 then frame 3C,00,00(+3C) -> cfg_o all zero, wr_stb=1, wr_addr=0.
REQ-036 Frame 77,00,11 -> err_stb, err_code=1, cfg_o unchanged; frame A5,09,11 (NUM_REGS=8) -> err_code=2.
REQ-037 Send A5 then stall TIMEOUT_CYC cycles -> err_stb, err_code=3, busy=0; ss_n high after 1 byte -> err_code=4.
REQ-038 CHECKSUM_EN: A5,01,55,00 -> err_code=5, no wr_stb; A5,01,55,F1 -> cfg_o[15:8]=0x55.
REQ-039 Assert rst_n low between byte 2 and 3 -> no wr_stb, all outputs reset values; next full frame commits normally.
